// File: rtl/riscv_pkg.sv
// Shared core constants and the fetch-buffer entry type.
//   XLEN/ILEN   : address and instruction widths
//   FETCH_DEPTH : default instruction-buffer depth
//   RESET_PC    : first fetch address after reset
//   NOP         : canonical addi x0,x0,0
package riscv_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned FETCH_DEPTH = 4;

    localparam logic [XLEN-1:0] RESET_PC = 64'h0;
    localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : synchronous clear; wins over push and pop
//   push, push_data : write an entry (accepted when not full, or full with pop)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry
//   count/full/empty: registered occupancy status
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Push into a full buffer is only legal when the head leaves this cycle.
    always_comb begin
        do_pop  = pop && !empty_q;
        do_push = push && (!full_q || do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointers and occupancy flags.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
        full  = full_q;
        empty = empty_q;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to
// instruction memory, buffers in-order responses and hands {pc, instr}
// pairs to decode. A redirect flushes the buffer and discards the responses
// of every request still outstanding.
//   clk, reset                   : clock, synchronous active-high reset
//   imem_req_valid/ready/addr    : fetch request channel
//   imem_rsp_valid/data          : in-order fetch responses, latency >= 1
//   redirect_valid/pc            : taken branch/jump from execute
//   if_valid/ready, if_pc/instr  : head instruction towards decode
module if_fetch_unit #(
    parameter int unsigned      XLEN     = riscv_pkg::XLEN,
    parameter int unsigned      ILEN     = riscv_pkg::ILEN,
    parameter int unsigned      DEPTH    = riscv_pkg::FETCH_DEPTH,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned EW  = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   drop_cnt_q;
    logic [XLEN-1:0] redirect_target;
    logic [CW1-1:0]  credit_used;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsb;

    // Request credit, handshakes and response steering.
    always_comb begin
        redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
        unused_redirect_lsb = ^redirect_pc[1:0];
        credit_used         = CW1'(inflight_q) + CW1'(fifo_count);
        imem_req_valid      = !reset && !redirect_valid && (credit_used < CW1'(DEPTH));
        imem_req_addr       = fetch_pc_q;
        req_fire            = imem_req_valid && imem_req_ready;
        rsp_fire            = imem_rsp_valid;
        rsp_drop            = rsp_fire && (drop_cnt_q != '0);
        push                = rsp_fire && !rsp_drop && !redirect_valid;
        if_valid            = !fifo_empty && !reset;
        pop                 = if_valid && if_ready;
        if_pc               = fifo_head[EW-1:ILEN];
        if_instr            = if_valid ? fifo_head[ILEN-1:0] : ILEN'(riscv_pkg::NOP);
    end

    // Fetch PC, response PC and outstanding/drop counters. A redirect turns
    // every request still in flight after this cycle into a drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_fire);
            if (redirect_valid) begin
                fetch_pc_q <= redirect_target;
                resp_pc_q  <= redirect_target;
                drop_cnt_q <= inflight_q - CW'(rsp_fire);
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
                if (push)     resp_pc_q  <= resp_pc_q + XLEN'(4);
                if (rsp_drop) drop_cnt_q <= drop_cnt_q - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({resp_pc_q, imem_rsp_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The credit rule must keep the buffer from ever overflowing.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop))
        else $error("fetch buffer overflow");

    // A response with nothing outstanding would underflow inflight.
    a_no_inflight_underflow : assert property (@(posedge clk) disable iff (reset)
        rsp_fire |-> (inflight_q != '0))
        else $error("response with no request outstanding");

    // Drops are a subset of outstanding requests, so drop_cnt cannot underflow.
    a_drop_le_inflight : assert property (@(posedge clk) disable iff (reset)
        drop_cnt_q <= inflight_q)
        else $error("drop count exceeds outstanding requests");

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end of the `riscv` core; feeds the `Instruction`/`PC_Output` path into decode.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses of variable latency and buffers them in a small FIFO.
- Presents {pc, instruction} pairs to decode with valid/ready.
- A redirect from execute (taken branch/jump) flushes buffered and in-flight fetches.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- DEPTH, 4, instruction buffer entries; also the maximum number of outstanding requests plus buffered entries.
- RESET_PC, 64'h0, fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency >= 1.
- imem_rsp_data  in  ILEN  fetched instruction.
- redirect_valid  in  1  taken branch/jump.
- redirect_pc  in  XLEN  new fetch target.
- if_valid  out  1  buffered instruction available to decode.
- if_ready  in  1  decode consumes head.
- if_pc  out  XLEN  PC of head instruction (drives PC_Output).
- if_instr  out  ILEN  head instruction (drives Instruction).

Behaviour:
- Reset (sync, active-high)
  - fetch_pc=RESET_PC; inflight=0; drop_cnt=0; FIFO empty.
  - if_valid=0, imem_req_valid=0 during the reset cycle.
  - Memory shares the reset, so no pre-reset responses arrive afterwards.
  - Reset mid-operation discards everything.
- Request issue
  - imem_req_valid = !reset && !redirect_valid && (inflight + fifo_count < DEPTH).
  - imem_req_addr = fetch_pc.
  - req_fire = valid & ready. On req_fire: fetch_pc += 4, inflight += 1.
  - Address is stable while valid & !ready, except on redirect, when valid is forced low.
- Response
  - rsp_fire = imem_rsp_valid. On rsp_fire: inflight -= 1.
  - If drop_cnt > 0, discard the response and decrement drop_cnt.
  - Otherwise push {pc, data} into the FIFO. The pushed pc comes from a resp_pc register: loaded with fetch_pc on redirect/reset, +4 per accepted (non-dropped) response.
  - The credit rule guarantees the FIFO never overflows. An overflow assertion must fire if it does.
- Output
  - if_valid = FIFO non-empty; if_pc/if_instr = head, registered.
  - Pop on if_valid & if_ready. Simultaneous push+pop is allowed when full or empty.
  - Latency: request accepted cycle N, response at N+L, if_valid at N+L+1.
  - With L=1 and if_ready=1, steady-state throughput is 1 instruction/cycle.
- Redirect (redirect_valid=1 in cycle N; takes priority over all else)
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}; resp_pc <= the same.
  - FIFO flushed. A pop or response in cycle N is ignored/discarded.
  - drop_cnt <= inflight - rsp_fire, i.e. every request still outstanding after cycle N.
  - No request is issued in cycle N.
  - Back-to-back redirects: each recomputes drop_cnt from the current inflight; the last target wins.
- Counters are $clog2(DEPTH+1) bits. inflight and drop_cnt never underflow; an assertion must cover this.

Decomposition:
- riscv_pkg holds XLEN, ILEN, RESET_PC, NOP (32'h00000013), and the fetch-entry struct {pc, instr}.
- One sub-module: fetch_fifo. It is a synchronous FIFO of DEPTH entries with push, pop, synchronous flush, count, full and empty. Flush has priority over push and pop.

Test Plan:
- Reset released at t0, memory L=1, if_ready=1, imem words 0x00500293 onward.
  - Requests at addresses 0x0, 0x4, 0x8, ….
  - if_valid first rises 2 cycles after the first request fire, with if_pc=0x0, then 0x4, 0x8 on consecutive cycles.
- if_ready=0, L=1.
  - Exactly 4 requests fire (0x0–0xC), then imem_req_valid=0.
  - After if_ready=1: pcs 0x0, 0x4, 0x8, 0xC in order, then fetch resumes at 0x10.
- L=3, redirect_pc=0x100 while 2 requests are in flight.
  - Both stale responses are discarded.
  - The next if_pc is 0x100 with data from 0x100; no request fires in the redirect cycle.
- Redirect in the same cycle as a pop and a response, FIFO holding 2 entries.
  - if_valid=0 the next cycle; no stale pc ever appears.
- redirect_pc=0x102 → imem_req_addr=0x100 and if_pc=0x100.
- Reset asserted with FIFO full and 2 in flight.
  - Next cycle if_valid=0.
  - After release, the first request is at RESET_PC and inflight/drop_cnt are 0.
